// File: rtl/soc_periph_evt_tx.sv
// SoC-side event transmitter: captures peripheral event pulses, grants them round-robin into
// a small FIFO and drains it over valid/ready. Optional lost-event counter: SOC_PERIPH_EVT_TX_LOST_CNT_EN.
module soc_periph_evt_tx #(
    parameter int NB_SRC     = 16,
    parameter int EVNT_WIDTH = 8,
    parameter int ID_BASE    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_SRC-1:0]     evt_i,
    input  logic [NB_SRC-1:0]     evt_mask_i,
    output logic                  soc_periph_evt_valid_o,
    input  logic                  soc_periph_evt_ready_i,
    output logic [EVNT_WIDTH-1:0] soc_periph_evt_data_o,
    output logic                  lost_evt_o,
    output logic [15:0]           lost_cnt_o,
    input  logic                  lost_cnt_clr_i
);

    localparam int PTR_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]        LP_NB      = (PTR_W+1)'(NB_SRC);
    localparam logic [PTR_W-1:0]      LP_LAST    = PTR_W'(NB_SRC - 1);
    localparam logic [PTR_W-1:0]      LP_PTR_ONE = PTR_W'(1);
    localparam logic [AW-1:0]         LP_A_ONE   = AW'(1);
    localparam logic [AW:0]           LP_C_ONE   = (AW+1)'(1);
    localparam logic [AW:0]           LP_DEPTH   = (AW+1)'(FIFO_DEPTH);
    localparam logic [EVNT_WIDTH-1:0] LP_ID_BASE = EVNT_WIDTH'(ID_BASE);

    logic [NB_SRC-1:0]     r_pending;
    logic [PTR_W-1:0]      r_ptr;
    logic [EVNT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_lost_evt;

    logic [NB_SRC-1:0]     w_cap;
    logic [2*NB_SRC-1:0]   w_pend_dbl;
    logic [NB_SRC-1:0]     w_pend_rot;
    logic [PTR_W-1:0]      w_off;
    logic                  w_any;
    logic [PTR_W:0]        w_gnt_sum;
    logic [PTR_W:0]        w_gnt_wrap;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [NB_SRC-1:0]     w_gnt_oh;
    logic [EVNT_WIDTH-1:0] w_push_id;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [NB_SRC-1:0]     w_lost;

    assign w_cap   = evt_i & evt_mask_i;
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    // Rotate pending so the pointer position lands at bit 0, then take the lowest set bit.
    assign w_pend_dbl = {r_pending, r_pending} >> r_ptr;
    assign w_pend_rot = w_pend_dbl[NB_SRC-1:0];

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int k = NB_SRC - 1; k >= 0; k--) begin
            if (w_pend_rot[k]) begin
                w_off = PTR_W'(k);
                w_any = 1'b1;
            end
        end
    end

    assign w_gnt_sum  = {1'b0, w_off} + {1'b0, r_ptr};
    assign w_gnt_wrap = w_gnt_sum - LP_NB;
    assign w_gnt_idx  = (w_gnt_sum >= LP_NB) ? w_gnt_wrap[PTR_W-1:0] : w_gnt_sum[PTR_W-1:0];

    assign w_push    = w_any & ~w_full;
    assign w_pop     = ~w_empty & soc_periph_evt_ready_i;
    assign w_gnt_oh  = w_push ? (NB_SRC'(1) << w_gnt_idx) : '0;
    assign w_push_id = LP_ID_BASE + EVNT_WIDTH'(w_gnt_idx);

    // A source re-firing while still pending and not granted this cycle loses that event.
    assign w_lost = w_cap & r_pending & ~w_gnt_oh;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_lost_evt <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_gnt_oh) | w_cap;
            r_lost_evt <= |w_lost;
            if (w_push) begin
                r_ptr <= (w_gnt_idx == LP_LAST) ? '0 : (w_gnt_idx + LP_PTR_ONE);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_A_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_A_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_C_ONE;
                2'b01:   r_count <= r_count - LP_C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; visibility is governed entirely by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_id;
        end
    end

    assign soc_periph_evt_valid_o = ~w_empty;
    assign soc_periph_evt_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign lost_evt_o             = r_lost_evt;

`ifdef SOC_PERIPH_EVT_TX_LOST_CNT_EN
    logic [15:0] r_lost_cnt;
    logic [16:0] w_lost_pc;
    logic [16:0] w_cnt_sum;

    always_comb begin
        w_lost_pc = '0;
        for (int k = 0; k < NB_SRC; k++) begin
            w_lost_pc = w_lost_pc + 17'(w_lost[k]);
        end
    end

    assign w_cnt_sum = {1'b0, r_lost_cnt} + w_lost_pc;

    // Clear wins over the old value but still counts losses of the clearing cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lost_cnt <= '0;
        end else if (lost_cnt_clr_i) begin
            r_lost_cnt <= w_lost_pc[15:0];
        end else if (w_cnt_sum[16]) begin
            r_lost_cnt <= 16'hFFFF;
        end else begin
            r_lost_cnt <= w_cnt_sum[15:0];
        end
    end

    assign lost_cnt_o = r_lost_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = lost_cnt_clr_i;
    assign lost_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_soc_periph_evt_tx.sv
// Directed bench for soc_periph_evt_tx (ID_BASE=0x20, other parameters at defaults).
module tb_soc_periph_evt_tx;

    logic        clk;
    logic        rst;
    logic [15:0] evt;
    logic [15:0] mask;
    logic        valid;
    logic        ready;
    logic [7:0]  data;
    logic        lost_evt;
    logic [15:0] lost_cnt;
    logic        clr;

    int n_chk = 0;
    int n_bad = 0;
    int lost_seen = 0;
    int base;
    int vcount;
    logic [7:0] got [16];
    int got_n;

`ifdef SOC_PERIPH_EVT_TX_LOST_CNT_EN
    localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
    localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

    soc_periph_evt_tx #(
        .NB_SRC    (16),
        .EVNT_WIDTH(8),
        .ID_BASE   (32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .evt_i                 (evt),
        .evt_mask_i            (mask),
        .soc_periph_evt_valid_o(valid),
        .soc_periph_evt_ready_i(ready),
        .soc_periph_evt_data_o (data),
        .lost_evt_o            (lost_evt),
        .lost_cnt_o            (lost_cnt),
        .lost_cnt_clr_i        (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lost_evt === 1'b1) lost_seen <= lost_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Each sample with valid high (ready held high) is one delivered ID.
    task automatic collect(input string tag, input int n, input int bound);
        got_n = 0;
        for (int c = 0; c < bound; c++) begin
            if (valid === 1'b1 && got_n < 16) begin
                got[got_n] = data;
                got_n++;
            end
            tick();
            if (got_n >= n) break;
        end
        check(tag, got_n, n);
    endtask

    initial begin
        rst   = 1'b1;
        evt   = '0;
        mask  = '1;
        ready = 1'b1;
        clr   = 1'b0;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_lost_evt", lost_evt, 0);
        check("rst_lost_cnt", lost_cnt, 0);
        rst = 1'b0;
        tick();

        // T1: single event, two-cycle latency
        evt = 16'h0008;
        tick();
        evt = '0;
        check("t1_valid_n1", valid, 0);
        tick();
        check("t1_valid_n2", valid, 1);
        check("t1_data_n2", data, 8'h23);
        tick();
        check("t1_valid_n3", valid, 0);
        check("t1_data_n3", data, 0);

        // T2: simultaneous pulses, round-robin from pointer 0 then pointer 10
        do_reset();
        base = lost_seen;
        evt = 16'h0221;
        tick();
        evt = '0;
        collect("t2a_count", 3, 10);
        check("t2a_id0", got[0], 8'h20);
        check("t2a_id1", got[1], 8'h25);
        check("t2a_id2", got[2], 8'h29);
        evt = 16'h0201;
        tick();
        evt = '0;
        collect("t2b_count", 2, 10);
        check("t2b_id0", got[0], 8'h20);
        check("t2b_id1", got[1], 8'h29);
        check("t2_no_loss", lost_seen - base, 0);

        // T3: back-pressure with more events than FIFO entries (pointer 10)
        ready = 1'b0;
        base = lost_seen;
        evt = 16'h285A;
        tick();
        evt = '0;
        for (int i = 0; i < 6; i++) tick();
        check("t3_valid_held", valid, 1);
        check("t3_head", data, 8'h2B);
        tick();
        check("t3_head_stable", data, 8'h2B);
        ready = 1'b1;
        collect("t3_count", 6, 20);
        check("t3_id0", got[0], 8'h2B);
        check("t3_id1", got[1], 8'h2D);
        check("t3_id2", got[2], 8'h21);
        check("t3_id3", got[3], 8'h23);
        check("t3_id4", got[4], 8'h24);
        check("t3_id5", got[5], 8'h26);
        check("t3_no_loss", lost_seen - base, 0);

        // T4: FIFO full, source 2 fires twice -> one loss
        do_reset();
        ready = 1'b0;
        base = lost_seen;
        evt = 16'h001B;
        tick();
        evt = '0;
        for (int i = 0; i < 5; i++) tick();
        check("t4_full_head", data, 8'h20);
        evt = 16'h0004;
        tick();
        evt = '0;
        check("t4_first_no_loss", lost_evt, 0);
        evt = 16'h0004;
        tick();
        evt = '0;
        check("t4_lost_pulse", lost_evt, 1);
        check("t4_lost_cnt", lost_cnt, EXP_CNT1);
        tick();
        check("t4_lost_pulse_end", lost_evt, 0);
        check("t4_lost_once", lost_seen - base, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_cnt_cleared", lost_cnt, 0);
        ready = 1'b1;
        collect("t4_count", 5, 20);
        check("t4_id0", got[0], 8'h20);
        check("t4_id1", got[1], 8'h21);
        check("t4_id2", got[2], 8'h23);
        check("t4_id3", got[3], 8'h24);
        check("t4_id4", got[4], 8'h22);

        // T5: asynchronous reset with queued and pending events
        do_reset();
        ready = 1'b0;
        evt = 16'h1124;
        tick();
        evt = '0;
        for (int i = 0; i < 3; i++) tick();
        check("t5_valid_before", valid, 1);
        check("t5_head_before", data, 8'h22);
        rst = 1'b1;
        #1;
        check("t5_valid_async", valid, 0);
        check("t5_data_async", data, 0);
        tick();
        tick();
        rst = 1'b0;
        ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid !== 1'b0) vcount++;
        end
        check("t5_no_stale", vcount, 0);

        // T6: masked source ignored; already-pending source still sent once
        base = lost_seen;
        mask = 16'hFF7F;
        evt = 16'h0080;
        tick();
        evt = '0;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid !== 1'b0) vcount++;
        end
        check("t6_masked_quiet", vcount, 0);
        check("t6_masked_no_loss", lost_seen - base, 0);
        mask = '1;
        evt = 16'h0080;
        tick();
        evt = '0;
        mask = 16'hFF7F;
        collect("t6_count", 1, 8);
        check("t6_id", got[0], 8'h27);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid !== 1'b0) vcount++;
            tick();
        end
        check("t6_sent_once", vcount, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
